// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Contents: sequencer state encoding, iteration counter width, operation
// encoding and a helper that turns a step count into the final step index.
package multdiv_pkg;

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StRun    = 2'd2,
    StFinish = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Index of the last step for an operation of n steps (n is 1..63).
  function automatic logic [CNT_W-1:0] last_index(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/multdiv_sequencer_iter_counter.sv
// Iteration index counter for the multiply/divide sequencer.
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset, clears the count
//   clr_i    synchronous clear (priority over enable)
//   en_i     count up by one
//   count_o  current count
module iter_counter
  import multdiv_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/multdiv_sequencer.sv
// Control FSM for the iterative multiply/divide unit. Sequences operand load,
// per-iteration step enables and the iteration index for the shared datapath,
// catches divide-by-zero before iterating and flags completion/exception.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ctrl_MULT, ctrl_DIV   one-cycle start pulses (MULT wins if both)
//   divisor_zero          datapath flag, sampled at the end of LOAD
//   mult_overflow         datapath flag, used combinationally in FINISH
//   op_is_div             latched operation (1 = divide)
//   load_operands         LOAD cycle strobe
//   step_en               one datapath iteration this cycle (RUN)
//   iter_count            step index during RUN, 0 otherwise
//   busy                  high in LOAD, RUN and FINISH
//   data_resultRDY        one-cycle completion pulse
//   data_exception        div-by-zero or mult overflow, qualified by data_resultRDY
// Optional: define MULTDIV_PERF_CNT_EN to add saturating perf_ops / perf_exc
// counters of completed operations and of completions with an exception.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 16,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             divisor_zero,
  input  logic             mult_overflow,
  output logic             op_is_div,
  output logic             load_operands,
  output logic             step_en,
  output logic [CNT_W-1:0] iter_count,
  output logic             busy,
  output logic             data_resultRDY,
  output logic             data_exception
`ifdef MULTDIV_PERF_CNT_EN
  ,
  output logic [15:0]      perf_ops,
  output logic [15:0]      perf_exc
`endif
);

  state_e           state_q, state_d;
  logic             op_is_div_q, op_is_div_d;
  logic             dz_q, dz_d;
  logic             load_q, step_q, busy_q, rdy_q;
  logic             start;
  logic             last_step;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_idx;

  assign start    = ctrl_MULT | ctrl_DIV;
  assign last_idx = op_is_div_q ? last_index(DIV_CYCLES) : last_index(MULT_CYCLES);
  assign last_step = (cnt == last_idx);

  // Any start pulse (including in FINISH) restarts at LOAD; an op aborted in
  // LOAD or RUN never reaches FINISH so it produces no result pulse.
  always_comb begin
    state_d     = state_q;
    op_is_div_d = op_is_div_q;
    dz_d        = dz_q;
    if (start) begin
      state_d     = StLoad;
      op_is_div_d = ctrl_MULT ? OP_MULT : OP_DIV;
      dz_d        = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StLoad: begin
          if (op_is_div_q && divisor_zero) begin
            state_d = StFinish;
            dz_d    = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
        StRun:    state_d = last_step ? StFinish : StRun;
        StFinish: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered decodes of the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      op_is_div_q <= OP_MULT;
      dz_q        <= 1'b0;
      load_q      <= 1'b0;
      step_q      <= 1'b0;
      busy_q      <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_is_div_q <= op_is_div_d;
      dz_q        <= dz_d;
      load_q      <= (state_d == StLoad);
      step_q      <= (state_d == StRun);
      busy_q      <= (state_d != StIdle);
      rdy_q       <= (state_d == StFinish);
    end
  end

  // Count only while staying in RUN; entering RUN or being anywhere else
  // holds the index at zero, so iter_count needs no output gating.
  iter_counter #(
    .W(CNT_W)
  ) u_iter_counter (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   ((state_d != StRun) || (state_q != StRun)),
    .en_i    (1'b1),
    .count_o (cnt)
  );

  assign op_is_div      = op_is_div_q;
  assign load_operands  = load_q;
  assign step_en        = step_q;
  assign iter_count     = cnt;
  assign busy           = busy_q;
  assign data_resultRDY = rdy_q;
  assign data_exception = rdy_q & (op_is_div_q ? dz_q : mult_overflow);

`ifdef MULTDIV_PERF_CNT_EN
  logic [15:0] perf_ops_q, perf_exc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_ops_q <= '0;
      perf_exc_q <= '0;
    end else if (rdy_q) begin
      if (perf_ops_q != 16'hFFFF) begin
        perf_ops_q <= perf_ops_q + 16'd1;
      end
      if (data_exception && (perf_exc_q != 16'hFFFF)) begin
        perf_exc_q <= perf_exc_q + 16'd1;
      end
    end
  end

  assign perf_ops = perf_ops_q;
  assign perf_exc = perf_exc_q;
`endif

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
Control FSM for the iterative multiply/divide unit in the ALU. Accepts one-cycle MULT/DIV start pulses and drives the shared shift/add datapath: operand load, per-iteration step enables and the iteration index. Detects divide-by-zero before iterating and reports completion and exception to the pipeline stall logic. Contains no arithmetic, only sequencing and the iteration counter.

Parameters:
MULT_CYCLES, 16, number of datapath steps for a multiply (radix-4 Booth, 32-bit); legal range 1..63
DIV_CYCLES, 32, number of datapath steps for a divide (restoring, 32-bit); legal range 1..63

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
ctrl_MULT  input  1  one-cycle pulse: start a multiply
ctrl_DIV  input  1  one-cycle pulse: start a divide
divisor_zero  input  1  datapath flag: latched divisor == 0, valid in LOAD cycle
mult_overflow  input  1  datapath flag: product overflows 32 bits, valid in FINISH cycle
op_is_div  output  1  latched operation: 1 = divide, 0 = multiply
load_operands  output  1  datapath loads operand/partial registers this cycle
step_en  output  1  datapath performs one iteration this cycle
iter_count  output  6  index of current step, 0..N-1 during RUN
busy  output  1  operation in progress (LOAD, RUN or FINISH)
data_resultRDY  output  1  one-cycle pulse: result valid on datapath output
data_exception  output  1  qualified with data_resultRDY: div-by-zero or mult overflow

Behaviour:
- Reset (async, any time incl. mid-operation): state IDLE, iter_count 0, op_is_div 0, every output 0; the in-flight op is discarded with no data_resultRDY.
- States: IDLE, LOAD, RUN, FINISH. All outputs are Moore decodes of state/registers except data_exception, which also uses mult_overflow combinationally in FINISH.
- Start: ctrl_MULT or ctrl_DIV high at a rising edge -> next state LOAD; op_is_div registered (1 for DIV). Both high together: MULT wins.
- LOAD (1 cycle): load_operands=1, busy=1, iteration counter cleared. Next: DIV with divisor_zero=1 -> FINISH with dz flag set, otherwise RUN.
- RUN: step_en=1 every cycle; iter_count = 0,1,...,N-1 with N = MULT_CYCLES or DIV_CYCLES; leaves to FINISH after the cycle in which iter_count == N-1. Exactly N step_en cycles per op.
- FINISH (1 cycle): data_resultRDY=1; data_exception = dz flag (DIV) or mult_overflow (MULT); next IDLE.
- Latency: start sampled at edge 0 -> LOAD cycle 1, RUN cycles 2..N+1, data_resultRDY cycle N+2 (18 MULT, 34 DIV at defaults); div-by-zero -> cycle 2.
- Restart: a start pulse in LOAD/RUN aborts the current op (no data_resultRDY) and goes to LOAD with the new op. In FINISH, the completed result is still reported that cycle; next state is LOAD instead of IDLE.
- iter_count is 0 outside RUN; the counter never wraps (N ≤ 63).
- busy is 0 only in IDLE.

Optional Feature:
MULTDIV_PERF_CNT_EN: defined -> extra output perf_ops[15:0] counting FINISH cycles and perf_exc[15:0] counting FINISH cycles with data_exception=1; both saturate at 16'hFFFF and are cleared by reset. Undefined -> ports and logic absent; all other behaviour identical.

Decomposition:
- Package multdiv_pkg: state enum (IDLE, LOAD, RUN, FINISH), CNT_W=6, op encoding (OP_MULT=0, OP_DIV=1).
- One sub-module iter_counter: CNT_W-bit up-counter with async reset, sync clear and enable; the sequencer instantiates it and compares against N-1.

Test Plan:
- ctrl_MULT pulse, mult_overflow=0 -> load_operands cycle 1, step_en cycles 2..17 with iter_count 0..15, data_resultRDY=1/data_exception=0 cycle 18, busy low cycle 19.
- ctrl_DIV pulse, divisor_zero=0 -> 32 step_en cycles, data_resultRDY cycle 34; with mult_overflow held 1 -> data_exception still 0.
- ctrl_DIV with divisor_zero=1 -> no step_en ever, data_resultRDY=1 and data_exception=1 at cycle 2.
- ctrl_MULT then ctrl_DIV at RUN step 5 -> no data_resultRDY for MULT, new LOAD next cycle with op_is_div=1, result at 34 cycles after DIV pulse.
- Reset asserted mid-RUN (iter_count=9) -> all outputs 0 immediately, no data_resultRDY after release; ctrl_MULT+ctrl_DIV together afterwards -> multiply (op_is_div=0).
- With MULTDIV_PERF_CNT_EN: 3 normal ops + 1 div-by-zero -> perf_ops=4, perf_exc=1.
